mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between a pipeline stage and the data
// cache. It handles direct word and byte accesses and LDI/STI-style indirect
// accesses, which first read a pointer word and then access the pointed-to
// address.
//
// Build option: define MEM_ALIGN_CHECK_EN to turn misaligned word addresses
// (direct, or loaded as a pointer) into an alignment fault with no data
// access. When it is not defined, the low address bits are cleared without
// notice and fault_out is tied to 0.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   valid_in                 stage holds a valid instruction
//   req_read/req_write       load / store (both set = load)
//   req_byte, req_indirect   byte size, two-access indirect
//   address_in, wdata_in     effective address, store data
//   stall_in                 downstream stall, holds DONE
//   dcache_rdata/resp        cache read data and response
//   dcache_*                 cache request (driven from registered state only)
//   rdata_out                aligned load result, bytes zero-extended
//   valid_out, mem_stall     completion, stage stall
//   fault_out                alignment fault while in DONE
//
// state | meaning
// IDLE  | wait for a request; capture address, data and type
// PTR   | indirect only: read the pointer word
// ACC   | data read or write at the final address
// DONE  | result presented; held while stall_in is high
module mem_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic                req_read,
    input  logic                req_write,
    input  logic                req_byte,
    input  logic                req_indirect,
    input  logic [ADDR_W-1:0]   address_in,
    input  logic [DATA_W-1:0]   wdata_in,
    input  logic                stall_in,
    input  logic [DATA_W-1:0]   dcache_rdata,
    input  logic                dcache_resp,
    output logic [ADDR_W-1:0]   dcache_address,
    output logic                dcache_read,
    output logic                dcache_write,
    output logic [DATA_W-1:0]   dcache_wdata,
    output logic [DATA_W/8-1:0] dcache_byte_enable,
    output logic [DATA_W-1:0]   rdata_out,
    output logic                valid_out,
    output logic                mem_stall,
    output logic                fault_out
);

    localparam int BYTES = DATA_W / 8;
    localparam int LSB_W = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, PTR, ACC, DONE} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              read_q;
    logic              byte_q;
    logic              ind_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] rdata_q;

    logic              mem_req;
    logic              align_fault_in;
    logic              ptr_fault;
    logic [ADDR_W-1:0] acc_src;
    logic [ADDR_W-1:0] acc_addr;
    logic [LSB_W-1:0]  acc_lane;
    logic [BYTES-1:0]  acc_be;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] rd_fmt;

    // A simultaneous read and write is handled as a read.
    assign mem_req = valid_in & (req_read | req_write);

`ifdef MEM_ALIGN_CHECK_EN
    assign align_fault_in = !req_byte && (|address_in[LSB_W-1:0]);
    assign ptr_fault      = !byte_q && (|dcache_rdata[LSB_W-1:0]);
`else
    assign align_fault_in = 1'b0;
    assign ptr_fault      = 1'b0;
`endif

    assign acc_src   = ind_q ? ptr_q : addr_q;
    assign acc_lane  = acc_src[LSB_W-1:0];
    assign acc_addr  = byte_q ? acc_src : (acc_src & ~LANE_MASK);
    assign acc_be    = byte_q ? (BYTES'(1) << acc_lane) : {BYTES{1'b1}};
    assign acc_wdata = byte_q ? {BYTES{wdata_q[7:0]}} : wdata_q;
    assign rd_fmt    = byte_q ? DATA_W'(dcache_rdata[{acc_lane, 3'b000} +: 8]) : dcache_rdata;

    always_comb begin
        state_d            = state_q;
        valid_out          = 1'b0;
        mem_stall          = 1'b0;
        dcache_read        = 1'b0;
        dcache_write       = 1'b0;
        dcache_address     = '0;
        dcache_wdata       = '0;
        dcache_byte_enable = '0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    mem_stall = 1'b1;
                    if (align_fault_in) begin
                        state_d = DONE;
                    end else if (req_indirect) begin
                        state_d = PTR;
                    end else begin
                        state_d = ACC;
                    end
                end else if (valid_in) begin
                    // Non-memory instruction passes straight through.
                    valid_out = 1'b1;
                end
            end
            PTR: begin
                mem_stall          = 1'b1;
                dcache_read        = 1'b1;
                dcache_address     = addr_q & ~LANE_MASK;
                dcache_byte_enable = {BYTES{1'b1}};
                if (dcache_resp) begin
                    state_d = ptr_fault ? DONE : ACC;
                end
            end
            ACC: begin
                mem_stall          = 1'b1;
                dcache_read        = read_q;
                dcache_write       = !read_q;
                dcache_address     = acc_addr;
                dcache_byte_enable = acc_be;
                dcache_wdata       = acc_wdata;
                if (dcache_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_out = 1'b1;
                if (!stall_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            byte_q  <= 1'b0;
            ind_q   <= 1'b0;
            ptr_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && mem_req) begin
                addr_q  <= address_in;
                wdata_q <= wdata_in;
                read_q  <= req_read;
                byte_q  <= req_byte;
                ind_q   <= req_indirect;
            end
            if (state_q == PTR && dcache_resp) begin
                ptr_q <= dcache_rdata[ADDR_W-1:0];
            end
            // Stores leave the last load result untouched.
            if (state_q == ACC && dcache_resp && read_q) begin
                rdata_q <= rd_fmt;
            end
        end
    end

    assign rdata_out = rdata_q;

`ifdef MEM_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if ((state_q == IDLE && mem_req && align_fault_in) ||
                     (state_q == PTR && dcache_resp && ptr_fault)) begin
            fault_q <= 1'b1;
        end else if (state_q == DONE && !stall_in) begin
            fault_q <= 1'b0;
        end
    end

    assign fault_out = fault_q;
`else
    assign fault_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, req_read, req_write, req_byte, req_indirect;
    logic [15:0] address_in, wdata_in;
    logic        stall_in;
    logic [15:0] dcache_rdata;
    logic        dcache_resp;
    logic [15:0] dcache_address;
    logic        dcache_read, dcache_write;
    logic [15:0] dcache_wdata;
    logic [1:0]  dcache_byte_enable;
    logic [15:0] rdata_out;
    logic        valid_out, mem_stall, fault_out;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .req_read(req_read), .req_write(req_write), .req_byte(req_byte),
        .req_indirect(req_indirect), .address_in(address_in), .wdata_in(wdata_in),
        .stall_in(stall_in), .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .dcache_address(dcache_address), .dcache_read(dcache_read),
        .dcache_write(dcache_write), .dcache_wdata(dcache_wdata),
        .dcache_byte_enable(dcache_byte_enable), .rdata_out(rdata_out),
        .valid_out(valid_out), .mem_stall(mem_stall), .fault_out(fault_out)
    );

    typedef struct {
        logic [15:0] addr;
        bit          wr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        logic [15:0] rdata;
        bit          fault;
        int          stall;
    } done_t;

    acc_t  acc_q[$];
    done_t done_q[$];
    int    lat_q[$];

    bit [15:0] ref_mem   [0:32767];
    bit [15:0] cache_mem [0:32767];
    logic [15:0] exp_rdata;
    bit resp_en, mon_en, late_pulse;

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Cache model: answers each access after the latency chosen by the stimulus.
    initial begin : responder
        bit busy;
        int cnt;
        acc_t e;
        logic [14:0] idx;
        busy = 1'b0;
        cnt = 0;
        dcache_resp = 1'b0;
        dcache_rdata = '0;
        forever begin
            @(negedge clk);
            dcache_resp = 1'b0;
            if (!resp_en) begin
                busy = 1'b0;
                if (late_pulse) begin
                    dcache_resp = 1'b1;
                    dcache_rdata = 16'hDEAD;
                end
                continue;
            end
            if (dcache_read || dcache_write) begin
                if (!busy) begin
                    busy = 1'b1;
                    check("access_expected", lat_q.size() > 0, 1);
                    cnt = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                end
                cnt--;
                if (cnt <= 0) begin
                    check("access_queued", acc_q.size() > 0, 1);
                    if (acc_q.size() > 0) begin
                        e = acc_q.pop_front();
                        check("acc_addr", dcache_address, e.addr);
                        check("acc_write", dcache_write, e.wr);
                        check("acc_read", dcache_read, !e.wr);
                        check("acc_be", dcache_byte_enable, e.be);
                        if (e.wr) check("acc_wdata", dcache_wdata, e.wdata);
                    end
                    idx = dcache_address[15:1];
                    dcache_rdata = dcache_write ? 16'($urandom) : cache_mem[idx];
                    if (dcache_write) begin
                        if (dcache_byte_enable[0]) cache_mem[idx][7:0]  = dcache_wdata[7:0];
                        if (dcache_byte_enable[1]) cache_mem[idx][15:8] = dcache_wdata[15:8];
                    end
                    dcache_resp = 1'b1;
                    busy = 1'b0;
                end
            end
        end
    end

    // Completion monitor: pops one expectation per completing valid_out cycle.
    initial begin : monitor
        int stall_cnt;
        done_t d;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                stall_cnt = 0;
                continue;
            end
            if (mem_stall) stall_cnt++;
            if (valid_out) begin
                check("done_no_access", dcache_read | dcache_write, 0);
                check("done_no_stall", mem_stall, 0);
            end
            if (valid_out && !stall_in) begin
                check("valid_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) begin
                    d = done_q.pop_front();
                    check("rdata_out", rdata_out, d.rdata);
                    check("fault_out", fault_out, d.fault);
                    check("stall_cycles", stall_cnt, d.stall);
                end
                stall_cnt = 0;
            end
        end
    end

    task automatic do_nop();
        done_t d;
        d.rdata = exp_rdata;
        d.fault = 1'b0;
        d.stall = 0;
        done_q.push_back(d);
        @(negedge clk);
        valid_in = 1'b1; req_read = 1'b0; req_write = 1'b0;
        req_byte = 1'($urandom_range(0, 1)); req_indirect = 1'($urandom_range(0, 1));
        address_in = 16'($urandom); wdata_in = 16'($urandom); stall_in = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic do_mem(input bit rd, input bit wr, input bit byt, input bit ind,
                          input logic [15:0] addr, input logic [15:0] wd,
                          input int lat1, input int lat2, input int stalls);
        done_t d;
        acc_t a;
        logic [15:0] eff, aa, mval;
        bit flt;
        int st, n;
        flt = 1'b0;
        st = 1;
`ifdef MEM_ALIGN_CHECK_EN
        if (!byt && addr[0]) flt = 1'b1;
`endif
        eff = addr;
        if (!flt && ind) begin
            a.addr = addr & 16'hFFFE; a.wr = 1'b0; a.be = 2'b11; a.wdata = '0;
            acc_q.push_back(a);
            lat_q.push_back(lat1);
            st += lat1;
            eff = ref_mem[a.addr[15:1]];
`ifdef MEM_ALIGN_CHECK_EN
            if (!byt && eff[0]) flt = 1'b1;
`endif
        end
        if (!flt) begin
            aa = byt ? eff : (eff & 16'hFFFE);
            a.addr = aa;
            a.wr = !rd;
            a.be = byt ? (aa[0] ? 2'b10 : 2'b01) : 2'b11;
            a.wdata = byt ? {wd[7:0], wd[7:0]} : wd;
            acc_q.push_back(a);
            lat_q.push_back(lat2);
            st += lat2;
            mval = ref_mem[aa[15:1]];
            if (rd) begin
                exp_rdata = byt ? {8'h00, (aa[0] ? mval[15:8] : mval[7:0])} : mval;
            end else if (byt) begin
                if (aa[0]) ref_mem[aa[15:1]][15:8] = wd[7:0];
                else       ref_mem[aa[15:1]][7:0]  = wd[7:0];
            end else begin
                ref_mem[aa[15:1]] = wd;
            end
        end
        d.rdata = exp_rdata;
        d.fault = flt;
        d.stall = st;
        done_q.push_back(d);

        @(negedge clk);
        valid_in = 1'b1; req_read = rd; req_write = wr; req_byte = byt; req_indirect = ind;
        address_in = addr; wdata_in = wd; stall_in = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid_out && n < 200);
        check("done_reached", valid_out, 1);
        for (int k = 0; k < stalls; k++) begin
            @(negedge clk);
            stall_in = 1'b1;
            #2;
            check("done_hold", valid_out, 1);
        end
        @(negedge clk);
        stall_in = 1'b0; valid_in = 1'b0;
        req_read = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_indirect = 1'b0;
    endtask

    initial begin : stimulus
        bit [15:0] v;
        bit rd, wr, byt, ind;
        int r, st;
        logic [1:0] rw;
        rst = 1'b1;
        valid_in = 1'b0; req_read = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_indirect = 1'b0; address_in = '0; wdata_in = '0; stall_in = 1'b0;
        resp_en = 1'b1; mon_en = 1'b1; late_pulse = 1'b0;
        exp_rdata = '0;
        for (int i = 0; i < 32768; i++) begin
            v = 16'($urandom);
            ref_mem[i] = v;
            cache_mem[i] = v;
        end
        ref_mem[16'h1234 >> 1] = 16'hBEEF; cache_mem[16'h1234 >> 1] = 16'hBEEF;
        ref_mem[16'h3000 >> 1] = 16'h4002; cache_mem[16'h3000 >> 1] = 16'h4002;
        ref_mem[16'h4002 >> 1] = 16'h1111; cache_mem[16'h4002 >> 1] = 16'h1111;

        repeat (3) @(negedge clk);
        check("rst_rdata", rdata_out, 16'h0000);
        check("rst_valid", valid_out, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_access", dcache_read | dcache_write, 0);
        check("rst_fault", fault_out, 0);
        rst = 1'b0;

        do_mem(1, 0, 0, 0, 16'h1234, 16'h0000, 1, 3, 0);
        do_mem(0, 1, 1, 0, 16'h2001, 16'h00A5, 1, 2, 0);
        do_mem(1, 0, 0, 1, 16'h3000, 16'h0000, 2, 1, 0);
        do_mem(1, 0, 0, 0, 16'h1234, 16'h0000, 1, 1, 5);
        do_nop();
        do_mem(1, 1, 1, 0, 16'h2001, 16'h0000, 1, 1, 0);
        do_mem(1, 0, 1, 0, 16'h2000, 16'h0000, 2, 2, 0);
        do_mem(1, 0, 0, 0, 16'h1235, 16'h0000, 1, 2, 0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                @(negedge clk);
                valid_in = 1'b0;
            end else if (r == 1) begin
                do_nop();
            end else begin
                rw = 2'($urandom_range(1, 3));
                rd = rw[0]; wr = rw[1];
                byt = 1'($urandom_range(0, 1));
                ind = ($urandom_range(0, 3) == 0);
                st = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
                do_mem(rd, wr, byt, ind, 16'($urandom_range(0, 127)), 16'($urandom),
                       $urandom_range(1, 4), $urandom_range(1, 4), st);
            end
        end

        repeat (4) @(negedge clk);
        check("acc_q_drained", acc_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        check("lat_q_drained", lat_q.size(), 0);

        // Reset in the middle of a load, then a stray response afterwards.
        resp_en = 1'b0;
        mon_en = 1'b0;
        @(negedge clk);
        valid_in = 1'b1; req_read = 1'b1; req_write = 1'b0; req_byte = 1'b0;
        req_indirect = 1'b0; address_in = 16'h0100;
        @(posedge clk);
        #1;
        check("pre_rst_read", dcache_read, 1);
        @(negedge clk);
        valid_in = 1'b0; req_read = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_read_drop", dcache_read | dcache_write, 0);
        check("rst_rdata_clear", rdata_out, 16'h0000);
        check("rst_fault_clear", fault_out, 0);
        late_pulse = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        late_pulse = 1'b0;
        check("late_resp_rdata", rdata_out, 16'h0000);
        check("late_resp_valid", valid_out, 0);
        check("late_resp_stall", mem_stall, 0);
        check("late_resp_access", dcache_read | dcache_write, 0);
        @(negedge clk);
        exp_rdata = '0;
        resp_en = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        do_mem(1, 0, 0, 0, 16'h1234, 16'h0000, 1, 2, 0);
        repeat (3) @(negedge clk);
        check("post_rst_drained", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
